// File: rtl/bullet_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : bullet_controller_if
// Purpose  : Tank-side bus of the bullet controller: controls in, bullet state out.
// Revision : 1.0
// ============================================================================
interface bullet_controller_if;
  logic       frame_tick;
  logic       fire;
  logic [9:0] tank_xpos;
  logic [9:0] tank_ypos;
  logic [1:0] tank_dir;
  logic [9:0] enemy_xpos;
  logic [9:0] enemy_ypos;
  logic       bullet_hit;
  logic [9:0] bullet1xpos;
  logic [9:0] bullet1ypos;
  logic [9:0] bullet2xpos;
  logic [9:0] bullet2ypos;
  logic [9:0] bullet3xpos;
  logic [9:0] bullet3ypos;
  logic [2:0] bullet_active;
  logic       fired;
  logic       hit_pulse;
  logic [7:0] score;

  modport master (
    output frame_tick, fire, tank_xpos, tank_ypos, tank_dir,
           enemy_xpos, enemy_ypos, bullet_hit,
    input  bullet1xpos, bullet1ypos, bullet2xpos, bullet2ypos,
           bullet3xpos, bullet3ypos, bullet_active, fired, hit_pulse, score
  );

  modport slave (
    input  frame_tick, fire, tank_xpos, tank_ypos, tank_dir,
           enemy_xpos, enemy_ypos, bullet_hit,
    output bullet1xpos, bullet1ypos, bullet2xpos, bullet2ypos,
           bullet3xpos, bullet3ypos, bullet_active, fired, hit_pulse, score
  );
endinterface
`default_nettype wire

// File: rtl/bullet_controller.sv
`default_nettype none
// ============================================================================
// Module   : bullet_controller
// Purpose  : Three-slot bullet spawn/move/retire engine for one tank, stepped on
//            frame_tick. Macro SCORE_COUNTER_EN enables the saturating hit score.
// Revision : 1.0
// ============================================================================
module bullet_controller #(
  parameter int BULLET_SPEED    = 4,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int TANK_SIZE       = 32,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic               clock,
  input  logic               reset_n,
  bullet_controller_if.slave bus
);
  localparam int              CD_W    = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [10:0]     SPEED_W = 11'(BULLET_SPEED);
  localparam logic [9:0]      SPEED_N = 10'(BULLET_SPEED);
  localparam logic [10:0]     X_MAX   = 11'(SCREEN_W - 1);
  localparam logic [10:0]     Y_MAX   = 11'(SCREEN_H - 1);
  localparam logic [10:0]     BOX     = 11'(TANK_SIZE);
  localparam logic [9:0]      HALF    = 10'(TANK_SIZE / 2);
  localparam logic [9:0]      PARK    = 10'h3FF;
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);
  localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);

  logic [2:0]      active_q, active_d;
  logic [9:0]      x_q [3];
  logic [9:0]      x_d [3];
  logic [9:0]      y_q [3];
  logic [9:0]      y_d [3];
  logic [1:0]      dir_q [3];
  logic [1:0]      dir_d [3];
  logic [CD_W-1:0] cooldown_q, cooldown_d;
  logic            pending_q, pending_d;
  logic            fired_q, fired_d;
  logic            hit_q, hit_d;
  logic            fire_req, spawn_done, leave;
  logic [10:0]     ex, ey;

  assign fire_req = pending_q | bus.fire;
  assign ex       = {1'b0, bus.enemy_xpos};
  assign ey       = {1'b0, bus.enemy_ypos};

  always_comb begin
    active_d   = active_q;
    cooldown_d = cooldown_q;
    pending_d  = fire_req;
    fired_d    = 1'b0;
    hit_d      = 1'b0;
    spawn_done = 1'b0;
    leave      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x_d[i]   = x_q[i];
      y_d[i]   = y_q[i];
      dir_d[i] = dir_q[i];
    end
    if (bus.frame_tick) begin
      pending_d = 1'b0;
      for (int i = 0; i < 3; i++) begin
        leave = 1'b0;
        if (active_q[i]) begin
          if (bus.bullet_hit &&
              ({1'b0, x_q[i]} > ex) && ({1'b0, x_q[i]} < ex + BOX) &&
              ({1'b0, y_q[i]} > ey) && ({1'b0, y_q[i]} < ey + BOX)) begin
            hit_d = 1'b1;
            leave = 1'b1;
          end else begin
            unique case (dir_q[i])
              2'd0: begin
                leave  = {1'b0, y_q[i]} < SPEED_W;
                y_d[i] = y_q[i] - SPEED_N;
              end
              2'd1: begin
                leave  = ({1'b0, x_q[i]} + SPEED_W) > X_MAX;
                x_d[i] = x_q[i] + SPEED_N;
              end
              2'd2: begin
                leave  = ({1'b0, y_q[i]} + SPEED_W) > Y_MAX;
                y_d[i] = y_q[i] + SPEED_N;
              end
              default: begin
                leave  = {1'b0, x_q[i]} < SPEED_W;
                x_d[i] = x_q[i] - SPEED_N;
              end
            endcase
          end
          if (leave) begin
            active_d[i] = 1'b0;
            x_d[i]      = PARK;
            y_d[i]      = PARK;
          end
        end
      end
      // Only slots free before this tick are candidates; freshly freed ones wait a tick.
      if (fire_req && (cooldown_q == '0)) begin
        for (int i = 0; i < 3; i++) begin
          if (!active_q[i] && !spawn_done) begin
            spawn_done  = 1'b1;
            active_d[i] = 1'b1;
            x_d[i]      = bus.tank_xpos + HALF;
            y_d[i]      = bus.tank_ypos + HALF;
            dir_d[i]    = bus.tank_dir;
          end
        end
      end
      if (spawn_done) begin
        fired_d    = 1'b1;
        cooldown_d = CD_LOAD;
      end else if (cooldown_q != '0) begin
        cooldown_d = cooldown_q - CD_ONE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_q   <= '0;
      cooldown_q <= '0;
      pending_q  <= 1'b0;
      fired_q    <= 1'b0;
      hit_q      <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        x_q[i]   <= PARK;
        y_q[i]   <= PARK;
        dir_q[i] <= 2'd0;
      end
    end else begin
      active_q   <= active_d;
      cooldown_q <= cooldown_d;
      pending_q  <= pending_d;
      fired_q    <= fired_d;
      hit_q      <= hit_d;
      for (int i = 0; i < 3; i++) begin
        x_q[i]   <= x_d[i];
        y_q[i]   <= y_d[i];
        dir_q[i] <= dir_d[i];
      end
    end
  end

  assign bus.bullet1xpos   = x_q[0];
  assign bus.bullet1ypos   = y_q[0];
  assign bus.bullet2xpos   = x_q[1];
  assign bus.bullet2ypos   = y_q[1];
  assign bus.bullet3xpos   = x_q[2];
  assign bus.bullet3ypos   = y_q[2];
  assign bus.bullet_active = active_q;
  assign bus.fired         = fired_q;
  assign bus.hit_pulse     = hit_q;

`ifdef SCORE_COUNTER_EN
  logic [7:0] score_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      score_q <= 8'd0;
    end else if (hit_q && (score_q != 8'hFF)) begin
      score_q <= score_q + 8'd1;
    end
  end

  assign bus.score = score_q;
`else
  assign bus.score = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bullet_controller.sv
`default_nettype none
// Testbench for bullet_controller: directed scenarios plus randomized traffic
// compared against a behavioural slot model.
module tb_bullet_controller;
  localparam int SPEED = 4;
  localparam int W     = 640;
  localparam int H     = 480;
  localparam int TS    = 32;
  localparam int CD    = 15;
  localparam int PARKV = 1023;
`ifdef SCORE_COUNTER_EN
  localparam bit SCORE_ON = 1'b1;
`else
  localparam bit SCORE_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  bullet_controller_if bus ();

  bullet_controller #(
    .BULLET_SPEED   (SPEED),
    .SCREEN_W       (W),
    .SCREEN_H       (H),
    .TANK_SIZE      (TS),
    .COOLDOWN_FRAMES(CD)
  ) dut (
    .clock  (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [9:0] ox [3];
  logic [9:0] oy [3];
  assign ox[0] = bus.bullet1xpos;
  assign oy[0] = bus.bullet1ypos;
  assign ox[1] = bus.bullet2xpos;
  assign oy[1] = bus.bullet2ypos;
  assign ox[2] = bus.bullet3xpos;
  assign oy[2] = bus.bullet3ypos;

  // Behavioural model: signed pixel arithmetic, on-screen test after each move.
  bit m_act [3];
  int m_x [3];
  int m_y [3];
  int m_dir [3];
  int m_cd, m_score;
  bit m_pend, m_fired, m_hit;
  int dxs [4] = '{0, 1, 0, -1};
  int dys [4] = '{-1, 0, 1, 0};

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 1'b0; m_x[i] = PARKV; m_y[i] = PARKV; m_dir[i] = 0;
    end
    m_cd = 0; m_score = 0; m_pend = 1'b0; m_fired = 1'b0; m_hit = 1'b0;
  endfunction

  function automatic void model_step(input bit tick);
    bit req, hit;
    bit pre_free [3];
    int nx, ny, k, ex, ey;
    if (SCORE_ON && m_hit && m_score < 255) m_score++;
    req = m_pend || (bus.fire === 1'b1);
    if (!tick) begin
      m_pend = req; m_fired = 1'b0; m_hit = 1'b0;
      return;
    end
    m_pend = 1'b0; hit = 1'b0;
    ex = int'(bus.enemy_xpos); ey = int'(bus.enemy_ypos);
    for (int i = 0; i < 3; i++) pre_free[i] = !m_act[i];
    for (int i = 0; i < 3; i++) begin
      if (!m_act[i]) continue;
      if (bus.bullet_hit && m_x[i] > ex && m_x[i] < ex + TS && m_y[i] > ey && m_y[i] < ey + TS) begin
        m_act[i] = 1'b0; m_x[i] = PARKV; m_y[i] = PARKV; hit = 1'b1;
        continue;
      end
      nx = m_x[i] + dxs[m_dir[i]] * SPEED;
      ny = m_y[i] + dys[m_dir[i]] * SPEED;
      if (nx < 0 || nx > W - 1 || ny < 0 || ny > H - 1) begin
        m_act[i] = 1'b0; m_x[i] = PARKV; m_y[i] = PARKV;
      end else begin
        m_x[i] = nx; m_y[i] = ny;
      end
    end
    k = -1;
    if (req && m_cd == 0)
      for (int i = 0; i < 3; i++) if (pre_free[i] && k < 0) k = i;
    if (k >= 0) begin
      m_act[k] = 1'b1;
      m_x[k]   = int'(bus.tank_xpos) + TS / 2;
      m_y[k]   = int'(bus.tank_ypos) + TS / 2;
      m_dir[k] = int'(bus.tank_dir);
      m_cd     = CD;
    end else if (m_cd > 0) begin
      m_cd--;
    end
    m_fired = (k >= 0); m_hit = hit;
  endfunction

  task automatic step(input bit tick);
    bus.frame_tick = tick;
    model_step(tick);
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin step(1'b1); step(1'b0); end
  endtask

  task automatic set_tank(input int x, input int y, input int d);
    bus.tank_xpos = 10'(x); bus.tank_ypos = 10'(y); bus.tank_dir = 2'(d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.fire = 1'b0; bus.bullet_hit = 1'b0; bus.frame_tick = 1'b0;
    bus.enemy_xpos = 10'd600; bus.enemy_ypos = 10'd440;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    ticks(5);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ox[i] !== 10'h3FF || oy[i] !== 10'h3FF) begin
        n_errors++; $display("FAIL reset_park slot%0d: got (%0d,%0d) expected (1023,1023)", i + 1, ox[i], oy[i]);
      end
    end
    n_checks++;
    if (bus.bullet_active !== 3'b000) begin
      n_errors++; $display("FAIL reset_active: got %b expected 000", bus.bullet_active);
    end
    n_checks++;
    if (bus.score !== 8'd0 || bus.fired !== 1'b0 || bus.hit_pulse !== 1'b0) begin
      n_errors++; $display("FAIL reset_flags: got score=%0d fired=%b hit=%b expected 0/0/0", bus.score, bus.fired, bus.hit_pulse);
    end
  endtask

  task automatic test_spawn_move();
    do_reset();
    set_tank(100, 200, 1);
    bus.fire = 1'b1; step(1'b0); bus.fire = 1'b0;
    step(1'b1);
    n_checks++;
    if (bus.bullet_active !== 3'b001 || ox[0] !== 10'd116 || oy[0] !== 10'd216 || bus.fired !== 1'b1) begin
      n_errors++; $display("FAIL spawn: got act=%b (%0d,%0d) fired=%b expected 001 (116,216) 1", bus.bullet_active, ox[0], oy[0], bus.fired);
    end
    step(1'b0);
    n_checks++;
    if (bus.fired !== 1'b0) begin
      n_errors++; $display("FAIL fired_width: got %b expected 0", bus.fired);
    end
    ticks(3);
    n_checks++;
    if (ox[0] !== 10'd128 || oy[0] !== 10'd216 || ox[1] !== 10'h3FF) begin
      n_errors++; $display("FAIL move3: got (%0d,%0d) slot2x=%0d expected (128,216) 1023", ox[0], oy[0], ox[1]);
    end
  endtask

  task automatic test_retire_edges();
    do_reset();
    set_tank(50, 3, 0);
    bus.fire = 1'b1; step(1'b1); bus.fire = 1'b0; step(1'b0);
    ticks(4);
    n_checks++;
    if (oy[0] !== 10'd3 || bus.bullet_active[0] !== 1'b1) begin
      n_errors++; $display("FAIL up_pre: got y=%0d act=%b expected 3 1", oy[0], bus.bullet_active[0]);
    end
    step(1'b1);
    n_checks++;
    if (bus.bullet_active[0] !== 1'b0 || ox[0] !== 10'h3FF || oy[0] !== 10'h3FF) begin
      n_errors++; $display("FAIL up_retire: got act=%b (%0d,%0d) expected 0 (1023,1023)", bus.bullet_active[0], ox[0], oy[0]);
    end
    step(1'b0);
    ticks(10);
    set_tank(604, 100, 1);
    bus.fire = 1'b1; step(1'b1); bus.fire = 1'b0;
    n_checks++;
    if (bus.bullet_active[0] !== 1'b1 || ox[0] !== 10'd620) begin
      n_errors++; $display("FAIL right_spawn: got act=%b x=%0d expected 1 620", bus.bullet_active[0], ox[0]);
    end
    step(1'b0);
    ticks(4);
    n_checks++;
    if (ox[0] !== 10'd636) begin
      n_errors++; $display("FAIL right_pre: got x=%0d expected 636", ox[0]);
    end
    step(1'b1);
    n_checks++;
    if (bus.bullet_active[0] !== 1'b0 || ox[0] !== 10'h3FF) begin
      n_errors++; $display("FAIL right_retire: got act=%b x=%0d expected 0 1023", bus.bullet_active[0], ox[0]);
    end
    step(1'b0);
  endtask

  task automatic test_hit();
    do_reset();
    set_tank(0, 0, 1);
    bus.fire = 1'b1; step(1'b1); bus.fire = 1'b0; step(1'b0);
    ticks(15);
    set_tank(194, 194, 2);
    bus.fire = 1'b1; step(1'b1); bus.fire = 1'b0;
    n_checks++;
    if (bus.bullet_active !== 3'b011 || ox[1] !== 10'd210 || oy[1] !== 10'd210) begin
      n_errors++; $display("FAIL hit_setup: got act=%b (%0d,%0d) expected 011 (210,210)", bus.bullet_active, ox[1], oy[1]);
    end
    step(1'b0);
    bus.enemy_xpos = 10'd200; bus.enemy_ypos = 10'd200; bus.bullet_hit = 1'b1;
    step(1'b1);
    bus.bullet_hit = 1'b0;
    n_checks++;
    if (bus.bullet_active !== 3'b001 || bus.hit_pulse !== 1'b1 || ox[1] !== 10'h3FF) begin
      n_errors++; $display("FAIL hit_retire: got act=%b hit=%b x=%0d expected 001 1 1023", bus.bullet_active, bus.hit_pulse, ox[1]);
    end
    step(1'b0);
    n_checks++;
    if (bus.hit_pulse !== 1'b0 || bus.score !== 8'(SCORE_ON)) begin
      n_errors++; $display("FAIL hit_score: got hit=%b score=%0d expected 0 %0d", bus.hit_pulse, bus.score, SCORE_ON);
    end
    ticks(14);
    set_tank(184, 194, 2);
    bus.fire = 1'b1; step(1'b1); bus.fire = 1'b0; step(1'b0);
    bus.bullet_hit = 1'b1;
    step(1'b1);
    bus.bullet_hit = 1'b0;
    n_checks++;
    if (bus.bullet_active !== 3'b011 || bus.hit_pulse !== 1'b0 || ox[1] !== 10'd200 || oy[1] !== 10'd214) begin
      n_errors++; $display("FAIL hit_strict: got act=%b hit=%b (%0d,%0d) expected 011 0 (200,214)", bus.bullet_active, bus.hit_pulse, ox[1], oy[1]);
    end
    step(1'b0);
    n_checks++;
    if (bus.score !== 8'(SCORE_ON)) begin
      n_errors++; $display("FAIL hit_strict_score: got %0d expected %0d", bus.score, SCORE_ON);
    end
  endtask

  task automatic test_hold_fire();
    bit exp_f;
    do_reset();
    set_tank(432, 100, 1);
    bus.fire = 1'b1;
    for (int t = 1; t <= 50; t++) begin
      step(1'b1);
      if (t == 1) set_tank(0, 300, 1);
      exp_f = (t == 1 || t == 17 || t == 33 || t == 50);
      n_checks++;
      if (bus.fired !== exp_f) begin
        n_errors++; $display("FAIL hold_fired tick%0d: got %b expected %b", t, bus.fired, exp_f);
      end
      if (t == 33 || t == 48) begin
        n_checks++;
        if (bus.bullet_active !== 3'b111) begin
          n_errors++; $display("FAIL hold_full tick%0d: got %b expected 111", t, bus.bullet_active);
        end
      end
      if (t == 49) begin
        n_checks++;
        if (bus.bullet_active !== 3'b110 || ox[0] !== 10'h3FF) begin
          n_errors++; $display("FAIL hold_exit: got act=%b x=%0d expected 110 1023", bus.bullet_active, ox[0]);
        end
      end
      if (t == 50) begin
        n_checks++;
        if (bus.bullet_active !== 3'b111 || ox[0] !== 10'd16 || oy[0] !== 10'd316) begin
          n_errors++; $display("FAIL hold_reuse: got act=%b (%0d,%0d) expected 111 (16,316)", bus.bullet_active, ox[0], oy[0]);
        end
      end
      step(1'b0);
    end
    bus.fire = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    set_tank(100, 100, 3);
    bus.fire = 1'b1; step(1'b1); bus.fire = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.bullet_active !== 3'b000 || ox[0] !== 10'h3FF || oy[0] !== 10'h3FF || bus.fired !== 1'b0) begin
      n_errors++; $display("FAIL async_reset: got act=%b (%0d,%0d) fired=%b expected 000 (1023,1023) 0", bus.bullet_active, ox[0], oy[0], bus.fired);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_random();
    int k, ex, ey;
    logic [2:0] exp_act;
    do_reset();
    set_tank(300, 200, 0);
    for (int n = 0; n < 600; n++) begin
      bus.fire = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0)
        set_tank($urandom_range(0, W - TS - 1), $urandom_range(0, H - TS - 1), $urandom_range(0, 3));
      k = $urandom_range(0, 2);
      if (m_act[k] && $urandom_range(0, 2) == 0) begin
        ex = m_x[k] - $urandom_range(0, 33); ey = m_y[k] - $urandom_range(0, 33);
        bus.enemy_xpos = 10'((ex < 0) ? 0 : ex);
        bus.enemy_ypos = 10'((ey < 0) ? 0 : ey);
        bus.bullet_hit = 1'b1;
      end else begin
        bus.enemy_xpos = 10'($urandom_range(0, W - TS));
        bus.enemy_ypos = 10'($urandom_range(0, H - TS));
        bus.bullet_hit = ($urandom_range(0, 9) == 0);
      end
      step($urandom_range(0, 2) == 0);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (ox[i] !== 10'(m_x[i]) || oy[i] !== 10'(m_y[i])) begin
          n_errors++; $display("FAIL rand_pos iter%0d slot%0d: got (%0d,%0d) expected (%0d,%0d)", n, i + 1, ox[i], oy[i], m_x[i], m_y[i]);
        end
      end
      exp_act = {m_act[2], m_act[1], m_act[0]};
      n_checks++;
      if (bus.bullet_active !== exp_act || bus.fired !== m_fired || bus.hit_pulse !== m_hit) begin
        n_errors++; $display("FAIL rand_flags iter%0d: got act=%b fired=%b hit=%b expected %b %b %b", n, bus.bullet_active, bus.fired, bus.hit_pulse, exp_act, m_fired, m_hit);
      end
      n_checks++;
      if (bus.score !== 8'(m_score)) begin
        n_errors++; $display("FAIL rand_score iter%0d: got %0d expected %0d", n, bus.score, m_score);
      end
    end
    bus.bullet_hit = 1'b0; bus.fire = 1'b0;
  endtask

  initial begin
    bus.frame_tick = 1'b0; bus.fire = 1'b0; bus.bullet_hit = 1'b0;
    set_tank(0, 0, 0);
    bus.enemy_xpos = 10'd0; bus.enemy_ypos = 10'd0;
    model_reset();
    test_reset();
    test_spawn_move();
    test_retire_edges();
    test_hit();
    test_hold_fire();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
